// File: rtl/hub75_pkg.sv
// Shared defaults, widths and state encoding for the HUB75 scan controller.
package hub75_pkg;

    localparam int unsigned COLS_DEF      = 60;
    localparam int unsigned ROWS_DEF      = 16;
    localparam int unsigned DIV_DEF       = 1;
    localparam int unsigned ON_CYC_DEF    = 256;
    localparam int unsigned BLANK_CYC_DEF = 2;

    localparam int unsigned COL_W = 7;
    localparam int unsigned ROW_W = 4;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned PH_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SHIFT = 3'd1,
        S_WAIT  = 3'd2,
        S_BLANK = 3'd3,
        S_LATCH = 3'd4
    } scan_state_t;

endpackage

// File: rtl/hub75_disp_timer.sv
// Display-time counter: loaded at each latch, counts down to zero, drives oe_n.
module hub75_disp_timer
    import hub75_pkg::*;
#(
    parameter int unsigned ON_CYC = ON_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic oe_n,
    output logic zero_c
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = CNT_W'(ON_CYC);
        end else if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
        end
    end

    // oe_n tracks the counter value it is registered alongside
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            oe_n <= 1'b1;
        end else begin
            cnt  <= cnt_next;
            oe_n <= (cnt_next == '0);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan-timing generator: shifts row N+1 while row N is displayed,
// blanks and latches between rows.
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned DIV       = DIV_DEF,
    parameter int unsigned ON_CYC    = ON_CYC_DEF,
    parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             sclk,
    output logic             lat,
    output logic             oe_n,
    output logic [ROW_W-1:0] addr,
    output logic             frame_done
);

    localparam logic [PH_W-1:0]  DIV_P     = PH_W'(DIV);
    localparam logic [PH_W-1:0]  PH_HI_END = PH_W'(2 * DIV - 1);
    localparam logic [PH_W-1:0]  PH_BL_END = PH_W'(BLANK_CYC - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

    scan_state_t      state;
    scan_state_t      state_next;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_next;
    logic [COL_W-1:0] col_next;
    logic [ROW_W-1:0] row_next;
    logic [ROW_W-1:0] addr_next;
    logic             sclk_next;
    logic             lat_next;
    logic             fd_next;
    logic             disp_load_c;
    logic             disp_zero_c;

    hub75_disp_timer #(
        .ON_CYC (ON_CYC)
    ) u_disp (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (disp_load_c),
        .oe_n   (oe_n),
        .zero_c (disp_zero_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= '0;
            col        <= '0;
            row        <= '0;
            sclk       <= 1'b0;
            lat        <= 1'b0;
            addr       <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            phase      <= phase_next;
            col        <= col_next;
            row        <= row_next;
            sclk       <= sclk_next;
            lat        <= lat_next;
            addr       <= addr_next;
            frame_done <= fd_next;
        end
    end

    // Phase counter doubles as sclk divider in SHIFT and blank timer in BLANK
    always_comb begin
        state_next  = state;
        phase_next  = phase;
        col_next    = col;
        row_next    = row;
        addr_next   = addr;
        sclk_next   = 1'b0;
        lat_next    = 1'b0;
        fd_next     = 1'b0;
        disp_load_c = 1'b0;

        unique case (state)
            S_IDLE: begin
                col_next   = '0;
                phase_next = '0;
                if (en) begin
                    state_next = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (phase == PH_HI_END) begin
                    phase_next = '0;
                    if (col == COL_LAST) begin
                        state_next = S_WAIT;
                    end else begin
                        col_next = col + COL_W'(1);
                    end
                end else begin
                    phase_next = phase + PH_W'(1);
                    sclk_next  = (phase_next >= DIV_P);
                end
            end

            S_WAIT: begin
                phase_next = '0;
                if (disp_zero_c) begin
                    state_next = S_BLANK;
                end
            end

            S_BLANK: begin
                if (phase == PH_BL_END) begin
                    phase_next = '0;
                    state_next = S_LATCH;
                    lat_next   = 1'b1;
                    addr_next  = row;
                end else begin
                    phase_next = phase + PH_W'(1);
                end
            end

            S_LATCH: begin
                disp_load_c = 1'b1;
                phase_next  = '0;
                col_next    = '0;
                row_next    = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                fd_next     = (row == ROW_LAST);
                state_next  = en ? S_SHIFT : S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench for hub75_scan_ctrl: three parameter sets, random enable
// profiles, expected events derived from row-level timing arithmetic.
module tb_hub75_scan_ctrl;

    localparam int NCFG = 3;
    localparam int HI   = 7200;
    localparam int NC   = 60;
    localparam int NR   = 16;
    localparam int CFG_DIV [NCFG] = '{1, 1, 3};
    localparam int CFG_ON  [NCFG] = '{256, 8, 256};
    localparam int CFG_BL  [NCFG] = '{2, 2, 3};

    typedef struct {
        int t;
        int a;
        int b;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit done [NCFG];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg
        localparam int DI = CFG_DIV[g];
        localparam int OI = CFG_ON[g];
        localparam int BI = CFG_BL[g];
        localparam int PERIOD = ((2 * DI * NC > OI) ? 2 * DI * NC : OI) + BI + 2;

        logic       rst_n;
        logic       en;
        logic [6:0] col;
        logic [3:0] row;
        logic       sclk;
        logic       lat;
        logic       oe_n;
        logic [3:0] addr;
        logic       frame_done;
        bit         go;
        bit         en_at [HI];
        ev_t        q_sclk [$];
        ev_t        q_lat [$];
        ev_t        q_oe [$];
        int         q_fd [$];

        hub75_scan_ctrl #(
            .COLS      (NC),
            .ROWS      (NR),
            .DIV       (DI),
            .ON_CYC    (OI),
            .BLANK_CYC (BI)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (en),
            .col        (col),
            .row        (row),
            .sclk       (sclk),
            .lat        (lat),
            .oe_n       (oe_n),
            .addr       (addr),
            .frame_done (frame_done)
        );

        // Row-by-row timeline: shift start, wait for display end, blank, latch.
        function automatic void build_model();
            int  s, r, dend, e, w, l, c;
            ev_t ev;
            r = 0;
            dend = 0;
            c = 0;
            while (c < HI && !en_at[c]) c++;
            if (c >= HI) return;
            s = c + 1;
            while (1) begin
                for (int k = 0; k < NC; k++) begin
                    ev.t = s + 2 * DI * k + DI;
                    ev.a = k;
                    ev.b = r;
                    if (ev.t < HI) q_sclk.push_back(ev);
                end
                e = s + 2 * DI * NC;
                w = (dend > e) ? dend : e;
                l = w + 1 + BI;
                if (l >= HI) break;
                ev.t = l;
                ev.a = r;
                ev.b = 0;
                q_lat.push_back(ev);
                if (r == NR - 1 && l + 1 < HI) q_fd.push_back(l + 1);
                dend = l + 1 + OI;
                if (dend < HI) begin
                    ev.t = l + 1;
                    ev.a = OI;
                    ev.b = 0;
                    q_oe.push_back(ev);
                end
                r = (r + 1) % NR;
                c = l;
                while (c < HI && !en_at[c]) c++;
                if (c >= HI) break;
                s = c + 1;
            end
        endfunction

        // Stimulus: enable profile, mid-display reset, then the scored run
        initial begin
            int st, a, len;
            bit seen;
            rst_n = 1'b0;
            en    = 1'b0;
            go    = 1'b0;
            for (int k = 0; k < HI; k++) en_at[k] = 1'b1;
            st = int'($urandom_range(20));
            for (int k = 0; k < st; k++) en_at[k] = 1'b0;
            for (int j = 0; j < 4; j++) begin
                a   = int'($urandom_range(HI - 300, 17 * PERIOD));
                len = int'($urandom_range(700, 1));
                for (int k = a; k < a + len && k < HI; k++) en_at[k] = 1'b0;
            end
            build_model();

            repeat (3) @(posedge clk);
            @(negedge clk) rst_n = 1'b1;
            @(posedge clk);
            #1 en = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 4000 && !seen; k++) begin
                @(posedge clk);
                #2;
                if (lat && addr == 4'd3) seen = 1'b1;
            end
            check("pre_lat_row3_seen", int'(seen), 1);
            repeat (4) @(posedge clk);
            #2 check("pre_displaying_row3", int'({oe_n, addr}), 3);
            #1 rst_n = 1'b0;
            #1 check("async_reset_outputs",
                     int'({col, row, sclk, lat, oe_n, addr, frame_done}), 32'h0000_0020);
            en = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk) begin
                rst_n = 1'b1;
                go    = 1'b1;
            end
            for (int k = 0; k < HI; k++) begin
                @(posedge clk);
                #1 en = en_at[k];
            end
        end

        // Monitor: pop an expectation for every event the DUT presents
        initial begin
            int   fall_t, exp_fall;
            logic sclk_p, oe_p;
            ev_t  ev;
            wait (go);
            sclk_p   = 1'b0;
            oe_p     = 1'b1;
            fall_t   = -1;
            exp_fall = -1;
            for (int k = 0; k < HI; k++) begin
                @(posedge clk);
                #2;
                if (sclk && !sclk_p) begin
                    if (q_sclk.size() == 0) begin
                        check("sclk_rise_unexpected", k, -1);
                    end else begin
                        ev = q_sclk.pop_front();
                        check("sclk_rise_time", k, ev.t);
                        check("sclk_col", int'(col), ev.a);
                        check("sclk_row", int'(row), ev.b);
                    end
                    exp_fall = k + DI;
                end
                if (!sclk && sclk_p) check("sclk_fall_time", k, exp_fall);
                if (lat) begin
                    check("lat_oe_sclk_idle", int'({oe_n, sclk}), 2);
                    if (q_lat.size() == 0) begin
                        check("lat_unexpected", k, -1);
                    end else begin
                        ev = q_lat.pop_front();
                        check("lat_time", k, ev.t);
                        check("lat_addr", int'(addr), ev.a);
                    end
                end
                if (frame_done) begin
                    if (q_fd.size() == 0) check("frame_done_unexpected", k, -1);
                    else check("frame_done_time", k, q_fd.pop_front());
                end
                if (!oe_n && oe_p) fall_t = k;
                if (oe_n && !oe_p) begin
                    if (q_oe.size() == 0) begin
                        check("oe_run_unexpected", k, -1);
                    end else begin
                        ev = q_oe.pop_front();
                        check("oe_run_start", fall_t, ev.t);
                        check("oe_run_len", k - fall_t, ev.a);
                    end
                end
                sclk_p = sclk;
                oe_p   = oe_n;
            end
            check("sclk_events_left", q_sclk.size(), 0);
            check("lat_events_left", q_lat.size(), 0);
            check("frame_done_events_left", q_fd.size(), 0);
            check("oe_runs_left", q_oe.size(), 0);
            done[g] = 1'b1;
        end
    end

    initial begin
        wait (done[0] && done[1] && done[2]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected all configurations done");
        $fatal(1, "timeout");
    end

endmodule
